// File: rtl/pid_ctrl_gen2_if.sv
// Drive-controller bus for pid_ctrl_gen2: error/speed/gain inputs and the clamped wheel-speed outputs.
// The master side supplies samples and gains; the slave side is the controller.
interface pid_ctrl_gen2_if #(
  parameter int ERR_W   = 12,
  parameter int FRWRD_W = 10,
  parameter int PC_W    = 6,
  parameter int DC_W    = 5
);
  logic                      moving;
  logic                      err_vld;
  logic signed [ERR_W-1:0]   error;
  logic [FRWRD_W-1:0]        frwrd;
  logic [PC_W-1:0]           p_coeff;
  logic [DC_W-1:0]           d_coeff;
  logic signed [FRWRD_W:0]   lft_spd;
  logic signed [FRWRD_W:0]   rght_spd;
  logic                      spd_vld;
  logic                      lft_sat;
  logic                      rght_sat;

  modport master (
    output moving, err_vld, error, frwrd, p_coeff, d_coeff,
    input  lft_spd, rght_spd, spd_vld, lft_sat, rght_sat
  );

  modport slave (
    input  moving, err_vld, error, frwrd, p_coeff, d_coeff,
    output lft_spd, rght_spd, spd_vld, lft_sat, rght_sat
  );
endinterface

// File: rtl/pid_ctrl_gen2.sv
// PID steering controller: runtime P/D gains, anti-windup integrator, clamped outputs, 2-stage pipeline.
// Define PID_SLEW_LIM_EN to rate-limit each speed output by SLEW_MAX per update.
module pid_ctrl_gen2 #(
  parameter int ERR_W    = 12,
  parameter int SAT_W    = 10,
  parameter int FRWRD_W  = 10,
  parameter int INT_W    = 15,
  parameter int I_SHIFT  = 6,
  parameter int D_DEPTH  = 3,
  parameter int DSAT_W   = 8,
  parameter int PC_W     = 6,
  parameter int DC_W     = 5,
  parameter int SLEW_MAX = 64
) (
  input logic            clk,
  input logic            rst,
  pid_ctrl_gen2_if.slave bus
);

  localparam int P_W   = SAT_W + PC_W + 1;
  localparam int D_W   = DSAT_W + DC_W + 1;
  localparam int I_W   = INT_W - I_SHIFT;
  localparam int M_PD  = (P_W > D_W) ? P_W : D_W;
  localparam int M_PDI = (M_PD > I_W) ? M_PD : I_W;
  localparam int PID_W = M_PDI + 2;
  localparam int SPD_W = FRWRD_W + 1;
  localparam int W     = ((PID_W > SPD_W) ? PID_W : SPD_W) + 1;

  localparam logic signed [W-1:0] SPD_HI = W'((1 << FRWRD_W) - 1);
  localparam logic signed [W-1:0] SPD_LO = ~SPD_HI;
  localparam logic signed [W-1:0] SLEW   = W'(SLEW_MAX);

`ifdef PID_SLEW_LIM_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  logic signed [SAT_W-1:0]  err_sat;
  logic signed [SAT_W-1:0]  hist [D_DEPTH];
  logic signed [SAT_W:0]    diff;
  logic signed [DSAT_W-1:0] diff_sat;
  logic signed [P_W-1:0]    p_term;
  logic signed [D_W-1:0]    d_term;
  logic signed [I_W-1:0]    i_term;
  logic signed [INT_W-1:0]  integ;
  logic signed [INT_W-1:0]  integ_nxt;
  logic signed [INT_W:0]    integ_sum;

  logic                     s1_vld;
  logic                     s1_moving;
  logic [FRWRD_W-1:0]       s1_frwrd;
  logic signed [P_W-1:0]    s1_p;
  logic signed [I_W-1:0]    s1_i;
  logic signed [D_W-1:0]    s1_d;

  logic signed [PID_W-1:0]  pid;
  logic signed [PID_W-1:0]  adj;
  logic signed [W-1:0]      l_wide;
  logic signed [W-1:0]      r_wide;
  logic                     l_clip;
  logic                     r_clip;
  logic signed [SPD_W-1:0]  l_tgt;
  logic signed [SPD_W-1:0]  r_tgt;
  logic signed [SPD_W-1:0]  l_nxt;
  logic signed [SPD_W-1:0]  r_nxt;

  logic signed [SPD_W-1:0]  lft_q;
  logic signed [SPD_W-1:0]  rght_q;
  logic                     vld_q;
  logic                     lsat_q;
  logic                     rsat_q;

  function automatic logic signed [SPD_W-1:0] slew_step(
    input logic signed [SPD_W-1:0] prev,
    input logic signed [SPD_W-1:0] tgt
  );
    logic signed [W-1:0] delta;
    delta = W'(tgt) - W'(prev);
    if (delta > SLEW)
      return SPD_W'(W'(prev) + SLEW);
    else if (delta < -SLEW)
      return SPD_W'(W'(prev) - SLEW);
    else
      return tgt;
  endfunction

  // Saturation: in range when every bit above the target sign bit matches the sign.
  always_comb begin
    if (bus.error[ERR_W-1:SAT_W-1] == {(ERR_W-SAT_W+1){bus.error[ERR_W-1]}})
      err_sat = bus.error[SAT_W-1:0];
    else
      err_sat = {bus.error[ERR_W-1], {(SAT_W-1){~bus.error[ERR_W-1]}}};

    if (diff[SAT_W:DSAT_W-1] == {(SAT_W-DSAT_W+2){diff[SAT_W]}})
      diff_sat = diff[DSAT_W-1:0];
    else
      diff_sat = {diff[SAT_W], {(DSAT_W-1){~diff[SAT_W]}}};
  end

  assign diff   = (SAT_W+1)'(err_sat) - (SAT_W+1)'(hist[D_DEPTH-1]);
  assign p_term = P_W'(err_sat) * P_W'($signed({1'b0, bus.p_coeff}));
  assign d_term = D_W'(diff_sat) * D_W'($signed({1'b0, bus.d_coeff}));
  assign i_term = I_W'(integ >>> I_SHIFT);

  assign integ_sum = (INT_W+1)'(integ) + (INT_W+1)'(err_sat);

  always_comb begin
    integ_nxt = integ;
    if (!bus.moving)
      integ_nxt = '0;
    else if (bus.err_vld) begin
      if (integ_sum[INT_W] != integ_sum[INT_W-1])
        integ_nxt = integ;
      else if ((lsat_q || rsat_q) && (err_sat[SAT_W-1] == integ[INT_W-1]))
        integ_nxt = integ;
      else
        integ_nxt = integ_sum[INT_W-1:0];
    end
  end

  assign pid    = PID_W'(s1_p >>> 1) + PID_W'(s1_i) + PID_W'(s1_d);
  assign adj    = pid >>> 3;
  assign l_wide = W'($signed({1'b0, s1_frwrd})) + W'(adj);
  assign r_wide = W'($signed({1'b0, s1_frwrd})) - W'(adj);

  always_comb begin
    l_clip = (l_wide > SPD_HI) || (l_wide < SPD_LO);
    r_clip = (r_wide > SPD_HI) || (r_wide < SPD_LO);
    l_tgt  = (l_wide > SPD_HI) ? SPD_HI[SPD_W-1:0] :
             (l_wide < SPD_LO) ? SPD_LO[SPD_W-1:0] : l_wide[SPD_W-1:0];
    r_tgt  = (r_wide > SPD_HI) ? SPD_HI[SPD_W-1:0] :
             (r_wide < SPD_LO) ? SPD_LO[SPD_W-1:0] : r_wide[SPD_W-1:0];
  end

  assign l_nxt = SLEW_EN ? slew_step(lft_q, l_tgt) : l_tgt;
  assign r_nxt = SLEW_EN ? slew_step(rght_q, r_tgt) : r_tgt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D_DEPTH; k++) hist[k] <= '0;
      integ     <= '0;
      s1_vld    <= 1'b0;
      s1_moving <= 1'b0;
      s1_frwrd  <= '0;
      s1_p      <= '0;
      s1_i      <= '0;
      s1_d      <= '0;
      lft_q     <= '0;
      rght_q    <= '0;
      vld_q     <= 1'b0;
      lsat_q    <= 1'b0;
      rsat_q    <= 1'b0;
    end else begin
      if (bus.err_vld) begin
        hist[0] <= err_sat;
        for (int k = 1; k < D_DEPTH; k++) hist[k] <= hist[k-1];
      end
      integ     <= integ_nxt;
      s1_vld    <= bus.err_vld;
      s1_moving <= bus.moving;
      s1_frwrd  <= bus.frwrd;
      s1_p      <= p_term;
      s1_i      <= i_term;
      s1_d      <= d_term;
      vld_q     <= s1_vld;
      if (s1_vld) begin
        // A stopped robot forces zero speed, bypassing clamp and slew.
        if (!s1_moving) begin
          lft_q  <= '0;
          rght_q <= '0;
          lsat_q <= 1'b0;
          rsat_q <= 1'b0;
        end else begin
          lft_q  <= l_nxt;
          rght_q <= r_nxt;
          lsat_q <= l_clip;
          rsat_q <= r_clip;
        end
      end
    end
  end

  assign bus.lft_spd  = lft_q;
  assign bus.rght_spd = rght_q;
  assign bus.spd_vld  = vld_q;
  assign bus.lft_sat  = lsat_q;
  assign bus.rght_sat = rsat_q;

endmodule

// File: doc/pid_ctrl_gen2.md
Name: pid_ctrl_gen2

Overview:
Parametrised second-generation PID steering controller for the drive datapath. It takes a signed heading error and a forward speed command, and produces signed, clamped left and right wheel speeds. Over the fixed-gain PID it adds:
- runtime P/D gains
- configurable derivative look-back depth
- conditional-integration anti-windup
- symmetric output clamping with saturation flags
- a valid-qualified 2-stage pipeline

Parameters:
ERR_W, 12, width of signed error input
SAT_W, 10, signed width error is saturated to
FRWRD_W, 10, width of unsigned forward speed; speed outputs are FRWRD_W+1 signed
INT_W, 15, signed integrator width
I_SHIFT, 6, integrator right-shift (arithmetic) giving I term
D_DEPTH, 3, number of err_vld samples between current error and derivative reference (>=1)
DSAT_W, 8, signed width the derivative difference is saturated to
PC_W, 6, width of unsigned p_coeff
DC_W, 5, width of unsigned d_coeff
SLEW_MAX, 64, max per-update output step (only used with PID_SLEW_LIM_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
moving  in  1  robot moving; low clears integrator and zeroes outputs
err_vld  in  1  error sample valid
error  in  ERR_W  signed heading error
frwrd  in  FRWRD_W  unsigned forward speed
p_coeff  in  PC_W  unsigned proportional gain
d_coeff  in  DC_W  unsigned derivative gain
lft_spd  out  FRWRD_W+1  signed left speed
rght_spd  out  FRWRD_W+1  signed right speed
spd_vld  out  1  one-cycle pulse: new speeds valid
lft_sat  out  1  lft_spd currently clamped
rght_sat  out  1  rght_spd currently clamped

Behaviour:
- Reset: clk edge with rst=1 zeroes all registers, including integrator, derivative history, pipeline, all outputs and flags.
- err_sat: error saturated to signed SAT_W range, [-2^(SAT_W-1), 2^(SAT_W-1)-1].
- P = err_sat * p_coeff. The coefficient is zero-extended, so the product is signed.
- Derivative history: D_DEPTH-entry shift register of err_sat, advanced only on err_vld.
  - diff = err_sat - oldest entry, saturated to DSAT_W.
  - D = diff_sat * d_coeff.
- I term: I = integrator >>> I_SHIFT, using the integrator value before this sample's update.
- Integrator update, per cycle, in priority order:
  - !moving -> 0.
  - else if !err_vld -> hold.
  - else if signed overflow of integrator + sext(err_sat) -> hold.
  - else if (lft_sat|rght_sat) and sign(err_sat)==sign(integrator) -> hold (anti-windup; err_sat==0 counts as positive).
  - else -> sum.
- Stage 1 (cycle N+1 for err_vld at N): registers P, I, D, moving, frwrd, and a valid bit.
- Stage 2 (cycle N+2):
  - pid = (P>>>1) + I + D, in a width with no overflow.
  - adj = pid>>>3.
  - l = frwrd + adj; r = frwrd - adj; both computed wide.
  - Each is clamped to [-2^FRWRD_W, 2^FRWRD_W-1]; the matching *_sat flag is set when clamped.
  - If stage-1 moving=0, both speeds are 0 and both flags are 0.
  - spd_vld pulses for 1 cycle.
- Holding and throughput:
  - Outputs and flags hold between spd_vld pulses.
  - Latency is exactly 2 cycles.
  - Throughput is 1 sample/cycle (back-to-back err_vld allowed).
- Gain changes take effect on the next err_vld sample.
- Reset mid-pipeline discards in-flight samples; no spd_vld is produced for them.

Optional Feature:
- PID_SLEW_LIM_EN defined:
  - At each stage-2 update, each speed moves from its previous output value by at most ±SLEW_MAX toward the clamped target.
  - The moving=0 forced-zero bypasses the limiter.
  - *_sat reflects the clamp only, not the slew limit.
- Undefined: no slew limiting.

Test Plan:
- Reset, then a single sample. Setup: defaults, p=16, d=7, integrator 0, history 0, moving=1, frwrd=0x200. Stimulus: err_vld with error=0x100. Response: spd_vld at N+2 with lft=879, rght=145, flags 0.
- Input saturation: error=0x7FF -> err_sat=511; error=0x800 -> err_sat=-512. Check P and the integrator increment for each.
- Integrator overflow hold: frwrd=0, 33 consecutive samples of 0x1FF -> integrator=16352 after 32 samples, then stays 16352; no saturation flags.
- Output clamp and anti-windup: frwrd=0x3FF, repeated error=0x1FF -> lft_spd=1023 with lft_sat=1; integrator stops growing once the flag is set; a negative error then resumes integration.
- moving=0 mid-stream: integrator is 0 the next cycle; the next spd_vld shows 0/0 with flags 0; moving=1 resumes normal output.
- With PID_SLEW_LIM_EN: outputs start at 0; target lft 879 -> successive updates give 64, 128, ... until reaching 879.
